// File: rtl/conv3x3_mac.sv
// conv3x3_mac: sequential KERNEL_SIZE x KERNEL_SIZE convolution MAC.
// It takes one pixel window per handshake, multiplies it element-wise with a
// locally stored signed kernel, accumulates one product per cycle and emits
// one signed result per window.
module conv3x3_mac #(
  parameter int unsigned BITS        = 9,
  parameter int unsigned KERNEL_SIZE = 3,
  parameter int unsigned OUT_BITS    = 2 * BITS + 4
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic                                  kernel_we,
  input  logic [3:0]                            kernel_addr,
  input  logic [BITS-1:0]                       kernel_data,
  input  logic                                  window_valid,
  input  logic [KERNEL_SIZE*KERNEL_SIZE*BITS-1:0] window_in,
  output logic                                  busy,
  output logic                                  out_valid,
  output logic [OUT_BITS-1:0]                   out_data,
  output logic                                  dropped
);

  localparam int unsigned NumTaps = KERNEL_SIZE * KERNEL_SIZE;
  localparam int unsigned IdxW    = (NumTaps > 1) ? $clog2(NumTaps) : 1;
  localparam logic [IdxW-1:0] LastIdx = IdxW'(NumTaps - 1);

  typedef enum logic [0:0] {StIdle, StMac} state_e;

  state_e                     state_q, state_d;
  logic [IdxW-1:0]            idx_q, idx_d;
  logic signed [OUT_BITS-1:0] acc_q, acc_d;
  logic signed [OUT_BITS-1:0] out_data_q, out_data_d;
  logic                       out_valid_q, out_valid_d;
  logic                       dropped_q, dropped_d;
  logic                       accept;
  logic                       weight_wr;

  // Programmable kernel, plus per-window snapshots of window and kernel
  logic signed [BITS-1:0] weight_q [NumTaps];
  logic signed [BITS-1:0] coef_q   [NumTaps];
  logic signed [BITS-1:0] win_q    [NumTaps];

  logic signed [2*BITS-1:0]   prod;
  logic signed [OUT_BITS-1:0] prod_ext;

  assign prod     = win_q[idx_q] * coef_q[idx_q];
  assign prod_ext = {{(OUT_BITS - 2 * BITS){prod[2*BITS-1]}}, prod};

  assign busy      = (state_q == StMac);
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign dropped   = dropped_q;

  assign weight_wr = kernel_we && (state_q == StIdle) && (32'(kernel_addr) < NumTaps);

  // Next-state logic: accept in idle, one product per cycle while accumulating
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    acc_d       = acc_q;
    out_data_d  = out_data_q;
    out_valid_d = 1'b0;
    dropped_d   = dropped_q;
    accept      = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (window_valid) begin
          accept  = 1'b1;
          idx_d   = '0;
          acc_d   = '0;
          state_d = StMac;
        end
      end
      StMac: begin
        if (window_valid) begin
          dropped_d = 1'b1;
        end
        acc_d = acc_q + prod_ext;
        idx_d = idx_q + 1'b1;
        if (idx_q == LastIdx) begin
          out_data_d  = acc_q + prod_ext;
          out_valid_d = 1'b1;
          idx_d       = '0;
          state_d     = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Control and result registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      idx_q       <= '0;
      acc_q       <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      dropped_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      acc_q       <= acc_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      dropped_q   <= dropped_d;
    end
  end

  // Kernel storage; writes only land while idle
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < NumTaps; k++) begin
        weight_q[k] <= '0;
      end
    end else if (weight_wr) begin
      weight_q[kernel_addr[IdxW-1:0]] <= kernel_data;
    end
  end

  // Snapshot window and kernel on accept so a same-edge write sees the old weight
  always_ff @(posedge clk) begin
    if (accept) begin
      for (int k = 0; k < NumTaps; k++) begin
        win_q[k]  <= window_in[k*BITS +: BITS];
        coef_q[k] <= weight_q[k];
      end
    end
  end

endmodule

// File: doc/conv3x3_mac.md
Name: conv3x3_mac

Overview:
- Downstream consumer of the line-buffer shift register.
- Accepts one KERNEL_SIZE x KERNEL_SIZE pixel window per handshake and multiplies it element-wise with a locally stored signed kernel.
- Accumulates the products sequentially, one product per cycle, and emits one signed convolution result per window.
- Its output feeds the later activation/pooling stage.

Parameters:
- BITS, 9, width of one pixel and one kernel weight (both two's complement).
- KERNEL_SIZE, 3, window edge length; window holds KERNEL_SIZE*KERNEL_SIZE elements.
- OUT_BITS, 2*BITS+4, width of the accumulator and the result; must satisfy 2^(OUT_BITS-2*BITS) >= KERNEL_SIZE*KERNEL_SIZE.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- kernel_we  in  1  kernel weight write strobe.
- kernel_addr  in  4  weight index k = row*KERNEL_SIZE+col.
- kernel_data  in  BITS  signed weight value.
- window_valid  in  1  window available (driven by shift register ready).
- window_in  in  KERNEL_SIZE*KERNEL_SIZE*BITS  element k at bits [k*BITS +: BITS], same k ordering as kernel_addr.
- busy  out  1  high while a window is being accumulated; new windows not accepted.
- out_valid  out  1  one-cycle pulse: out_data updated this cycle.
- out_data  out  OUT_BITS  signed sum over k of window[k]*weight[k]; held until next result.
- dropped  out  1  sticky: a window was offered while busy.

Behaviour:
- Reset (reset=1 at an edge): state IDLE, busy=0, out_valid=0, out_data=0, dropped=0, accumulator=0, all weights=0. Reset overrides every other input, including mid-computation; the in-flight window is discarded and no out_valid is produced for it.
- Kernel writes: at an edge with kernel_we=1, busy=0 and kernel_addr < KERNEL_SIZE*KERNEL_SIZE, weight[kernel_addr] <= kernel_data.
  - Writes with busy=1 or an out-of-range address are ignored, with no side effects.
  - A write and a window accept on the same edge are both performed; the accepted window uses the OLD weight.
- FSM has two states, IDLE and MAC.
- IDLE: at an edge with window_valid=1, the whole window_in is captured into an internal register.
  - idx <= 0, acc <= 0, state <= MAC, busy <= 1.
- MAC: each edge adds sign_extend(window[idx]*weight[idx]) to acc.
  - The product is a full signed 2*BITS value, sign-extended to OUT_BITS.
  - idx increments each edge.
  - On the edge with idx == KERNEL_SIZE*KERNEL_SIZE-1: out_data <= acc + last product, out_valid <= 1, busy <= 0, state <= IDLE.
- Latency: result visible KERNEL_SIZE*KERNEL_SIZE edges after the accept edge (9 for the default).
  - busy is high for exactly those cycles in between.
- out_valid is high for exactly one cycle, deasserting on the next edge unless that edge completes another window.
- Back-to-back: in the out_valid cycle busy=0, so a window presented then is accepted on the next edge. Throughput is one window per KERNEL_SIZE*KERNEL_SIZE+1 cycles.
- The captured window is frozen during MAC; changes on window_in do not affect the in-flight result.
- window_valid=1 at an edge while busy=1: the window is ignored and dropped <= 1. dropped clears only on reset.
- No saturation is applied. With the default parameters no overflow is possible: the worst case 9*(-256*-256)=589824 < 2^21.

Test Plan:
- Reset check: drive reset for 1 cycle, then idle 5 cycles -> busy=0, out_valid=0, out_data=0, dropped=0.
- Basic sum:
  - Stimulus: write all 9 weights = 1; present window elements k=0..8 with values 1..9 for one cycle.
  - Required: busy high 9 cycles, then out_valid pulse with out_data=45.
- Identity and ordering:
  - Stimulus: weights 0 except weight[4]=1; window values 10,20,...,90.
  - Required: out_data=50. Repeat with only weight[0]=1 -> out_data=10.
- Signed arithmetic:
  - Weights all 9'h1FF (-1) with window all 255 -> out_data=-2295.
  - Weights all -256 with window all -256 -> out_data=589824.
- Busy, drop and kernel freeze:
  - Stimulus: present a second window and a kernel write (addr 0, value 7) during busy.
  - Required: second window produces no result and dropped=1; weight[0] unchanged, checked by the next window result.
  - Stimulus: present a window exactly in the out_valid cycle.
  - Required: it is accepted and its result follows 10 cycles after the first result.
- Reset mid-op:
  - Stimulus: assert reset 4 cycles after accept.
  - Required: no out_valid follows; out_data=0; weights=0, so the next window yields 0.
